// File: rtl/pif_led_pkg.sv
// Shared mode encodings for the multi-channel PIF LED sequencer.
package pif_led_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ON      = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 2'b11;

endpackage

// File: rtl/pif_led_chan.sv
// One LED channel: committed mode, blink counter/phase, breathe duty ramp and registered drive.
module pif_led_chan
  import pif_led_pkg::*;
#(
  parameter int unsigned BLINK_TICKS = 8,
  parameter int unsigned PWM_W       = 8
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              tick,
  input  logic              commit,
  input  logic [PWM_W-1:0]  pwm_cnt,
  input  logic [MODE_W-1:0] mode,
  input  logic              start_phase,
  output logic              led
);

  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic [MODE_W-1:0] mode_q;
  logic              phase_q;
  logic [BW-1:0]     bcnt_q;
  logic [PWM_W-1:0]  duty_q;
  logic              dir_dn_q;
  logic              led_q;

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      mode_q   <= MODE_OFF;
      phase_q  <= 1'b0;
      bcnt_q   <= '0;
      duty_q   <= '0;
      dir_dn_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      // A commit restarts every pattern from its defined origin.
      if (commit) begin
        mode_q   <= mode;
        phase_q  <= start_phase;
        bcnt_q   <= '0;
        duty_q   <= '0;
        dir_dn_q <= 1'b0;
      end else if (tick) begin
        if (mode_q == MODE_BLINK) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        // Duty holds for one tick at each end of the ramp while the direction flips.
        if (mode_q == MODE_BREATHE) begin
          if (!dir_dn_q) begin
            if (duty_q == DUTY_MAX) dir_dn_q <= 1'b1;
            else                    duty_q   <= duty_q + 1'b1;
          end else begin
            if (duty_q == '0) dir_dn_q <= 1'b0;
            else              duty_q   <= duty_q - 1'b1;
          end
        end
      end

      unique case (mode_q)
        MODE_OFF:   led_q <= 1'b0;
        MODE_ON:    led_q <= 1'b1;
        MODE_BLINK: led_q <= phase_q;
        default:    led_q <= (pwm_cnt < duty_q);
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: rtl/pif_led_seq.sv
// Multi-channel LED sequencer: shared prescaler tick, tick-aligned config commit, per-channel
// OFF/ON/BLINK/BREATHE patterns.
module pif_led_seq
  import pif_led_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned PRESCALE_DIV = 1000000,
  parameter int unsigned BLINK_TICKS  = 8,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned PHASE_ALT    = 1
) (
  input  logic                  xclk,
  input  logic                  sys_rst,
  input  logic [2*NUM_CH-1:0]   cfg_mode,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [NUM_CH-1:0]     led,
  output logic                  tick
);

  localparam int unsigned PW = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0]       presc_q;
  logic                tick_q;
  logic                ready_q;
  logic [2*NUM_CH-1:0] pend_q;
  logic [PWM_W-1:0]    pwm_q;
  logic                commit;

  // Only a config already pending before the tick cycle may commit on it.
  assign commit = tick_q & ~ready_q;

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      presc_q <= PRE_LAST;
      tick_q  <= 1'b0;
      ready_q <= 1'b1;
      pend_q  <= '0;
      pwm_q   <= '0;
    end else begin
      tick_q  <= (presc_q == '0);
      presc_q <= (presc_q == '0) ? PRE_LAST : presc_q - 1'b1;
      pwm_q   <= pwm_q + 1'b1;
      if (cfg_valid && ready_q) begin
        pend_q  <= cfg_mode;
        ready_q <= 1'b0;
      end else if (commit) begin
        ready_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic START_PHASE = !((PHASE_ALT != 0) && (i % 2 == 1));

    pif_led_chan #(
      .BLINK_TICKS (BLINK_TICKS),
      .PWM_W       (PWM_W)
    ) u_chan (
      .xclk        (xclk),
      .sys_rst     (sys_rst),
      .tick        (tick_q),
      .commit      (commit),
      .pwm_cnt     (pwm_q),
      .mode        (pend_q[2*i +: MODE_W]),
      .start_phase (START_PHASE),
      .led         (led[i])
    );
  end

  assign cfg_ready = ready_q;
  assign tick      = tick_q;

endmodule
